// File: rtl/cpu_types_pkg.sv
// Shared core types: the machine word, the memory arbiter state encoding and
// a helper that sizes saturating counters from their limit.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  // Bits needed to hold 0..limit; a limit of 0 still gets one bit.
  function automatic int cnt_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// Up-counter that stops at LIMIT and never wraps; clear wins over increment.
module sat_counter
  import cpu_types_pkg::*;
#(
  parameter int LIMIT = 1,
  parameter int W     = cnt_width(LIMIT)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);

  localparam logic [W-1:0] MAX = W'(LIMIT);

  assign sat = (cnt == MAX);

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, with
// data priority, bounded fetch starvation and a sticky RAM-timeout flag.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255,
  parameter int AW           = $bits(word_t),
  parameter int DW           = $bits(word_t)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          iREN,
  input  logic [AW-1:0] iaddr,
  output logic          iwait,
  output logic [DW-1:0] iload,
  input  logic          dREN,
  input  logic          dWEN,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dstore,
  output logic          dwait,
  output logic [DW-1:0] dload,
  output logic          ramREN,
  output logic          ramWEN,
  output logic [AW-1:0] ramaddr,
  output logic [DW-1:0] ramstore,
  input  logic [DW-1:0] ramload,
  input  logic          ram_ack,
  output logic          ram_err
);

  localparam int SW = cnt_width(STARVE_LIMIT);
  localparam int TW = cnt_width(TIMEOUT);

  arb_state_t    state, state_nxt;
  logic          d_req;
  logic          i_done, d_done;
  logic          starve_sat, starve_force;
  logic          to_sat, to_hit;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] to_cnt;

  assign d_req        = dREN | dWEN;
  assign starve_force = (STARVE_LIMIT != 0) && starve_sat;
  assign to_hit       = (TIMEOUT != 0) && (state != IDLE) && to_sat;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ram_err <= 1'b0;
    end else if (to_hit) begin
      ram_err <= 1'b1;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path through it leaves a signal unassigned (no latches).
  always_comb begin
    state_nxt = state;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    iwait     = 1'b1;
    dwait     = 1'b1;
    iload     = '0;
    dload     = '0;
    i_done    = 1'b0;
    d_done    = 1'b0;

    unique case (state)
      IDLE: begin
        if (iREN && (!d_req || starve_force)) begin
          state_nxt = GRANT_I;
        end else if (d_req) begin
          state_nxt = GRANT_D;
        end
      end

      GRANT_I: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (!iREN) begin
          state_nxt = IDLE;
        end else if (ram_ack) begin
          iwait     = 1'b0;
          iload     = ramload;
          i_done    = 1'b1;
          state_nxt = IDLE;
        end
      end

      GRANT_D: begin
        // A write wins when the requester raises both strobes.
        ramREN   = dREN && !dWEN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!d_req) begin
          state_nxt = IDLE;
        end else if (ram_ack) begin
          dwait     = 1'b0;
          dload     = dWEN ? '0 : ramload;
          d_done    = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Data wins only while the fetch side has not yet waited STARVE_LIMIT grants.
  sat_counter #(
    .LIMIT (STARVE_LIMIT),
    .W     (SW)
  ) u_starve_cnt (
    .CLK (CLK),
    .RST (RST),
    .inc (d_done && iREN),
    .clr (i_done || (d_done && !iREN)),
    .cnt (starve_cnt),
    .sat (starve_sat)
  );

  sat_counter #(
    .LIMIT (TIMEOUT),
    .W     (TW)
  ) u_to_cnt (
    .CLK (CLK),
    .RST (RST),
    .inc (state != IDLE),
    .clr (state == IDLE),
    .cnt (to_cnt),
    .sat (to_sat)
  );

  starve_cnt_bounded: assert property (@(posedge CLK) disable iff (RST)
    starve_cnt <= SW'(STARVE_LIMIT));

  to_cnt_bounded: assert property (@(posedge CLK) disable iff (RST)
    to_cnt <= TW'(TIMEOUT));

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single-ported RAM between the instruction-fetch requester and the data requester of one pipelined core.
- Sits between the cache layer (icache/dcache) and the RAM, in the same position as a memory controller.
- Grants data over instruction by default.
- A starvation counter forces an instruction grant after a bounded run of data grants.
- Provides per-requester wait/load returns and a sticky RAM-timeout flag.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants (with fetch pending) before a forced fetch grant. 0 disables the forcing.
- TIMEOUT, 255: cycles a grant may wait for ram_ack before ram_err sets. 0 disables the timeout.
- AW, 32: address width.
- DW, 32: data word width.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- iREN  in  1  fetch read request.
- iaddr  in  AW  fetch address.
- iwait  out  1  1 = fetch not complete.
- iload  out  DW  fetch data, valid when iREN && !iwait.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  AW  data address.
- dstore  in  DW  write data.
- dwait  out  1  1 = data access not complete.
- dload  out  DW  read data, valid when dREN && !dwait.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  AW  RAM address.
- ramstore  out  DW  RAM write data.
- ramload  in  DW  RAM read data.
- ram_ack  in  1  RAM access complete this cycle.
- ram_err  out  1  sticky: a grant exceeded TIMEOUT.

Behaviour:
- Reset (CLK edge with RST=1):
  - state=IDLE, starve_cnt=0, to_cnt=0, ram_err=0.
  - Outputs: ramREN=ramWEN=0, ramaddr=0, ramstore=0, iwait=dwait=1, iload=dload=0.
  - Reset mid-grant abandons the access. The RAM strobes are low from the cycle after the reset edge; no completion is signalled.
- Requester contract: a requester holds its request, address and store data stable until its wait goes 0.
- States: IDLE, GRANT_I, GRANT_D.
- IDLE:
  - RAM strobes 0; both waits 1.
  - Next state:
    - GRANT_I if iREN && (!(dREN||dWEN) || (STARVE_LIMIT!=0 && starve_cnt==STARVE_LIMIT)).
    - Else GRANT_D if dREN||dWEN.
    - Else IDLE.
  - Arbitration decision registered: minimum one cycle from request to RAM strobe.
- GRANT_I:
  - ramREN=iREN, ramWEN=0, ramaddr=iaddr.
  - If ram_ack && iREN: iwait=0 and iload=ramload in the same cycle (combinational); starve_cnt<=0; next IDLE.
- GRANT_D:
  - ramREN=dREN&&!dWEN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore. dWEN has priority if both dREN and dWEN are high.
  - If ram_ack && (dREN||dWEN): dwait=0; dload=ramload on reads; next IDLE.
  - At completion, if iREN=1: starve_cnt<=starve_cnt+1, saturating at STARVE_LIMIT. If iREN=0: starve_cnt<=0.
- Request withdrawn during a grant (strobe input low and no ack that cycle): RAM strobes drop combinationally, no completion, next IDLE.
- Ack with no active request is ignored.
- Back-to-back: after a completion, the earliest next RAM strobe is two cycles later (IDLE cycle + grant). Minimum 3-cycle occupancy per access with a 1-cycle RAM.
- Timeout:
  - to_cnt counts cycles in a GRANT state and clears in IDLE.
  - When to_cnt==TIMEOUT (TIMEOUT!=0), ram_err<=1. ram_err is sticky until RST.
  - The grant continues waiting after the timeout; no abort.
- Widths: starve_cnt is $clog2(STARVE_LIMIT+1) bits, minimum 1. to_cnt is $clog2(TIMEOUT+1) bits, minimum 1. Both saturate and never wrap.
- No output may carry X after reset. Unused load outputs are driven 0 outside their completion cycle.

Decomposition:
- Package: arb_state_t enum {IDLE, GRANT_I, GRANT_D}, placed in cpu_types_pkg alongside word_t. AW/DW default to word_t width.
- One sub-module: sat_counter (parameterised width/limit, inc/clr, sat output). Instantiated twice, for starve_cnt and to_cnt.
- FSM and output mux live in mem_arbiter.

Test Plan:
- Reset and single fetch:
  - Stimulus: hold RST 2 cycles; iREN=1, iaddr=0x100; ram_ack 2 cycles after ramREN rises with ramload=0xDEADBEEF.
  - Required: ramREN rises 1 cycle after iREN; iwait=0 for exactly 1 cycle with iload=0xDEADBEEF; back to IDLE.
- Data priority:
  - Stimulus: iREN=1 and dWEN=1 (daddr=0x200, dstore=0x12345678) asserted in the same cycle; ram_ack after 1 cycle.
  - Required: ramWEN with ramaddr=0x200 first; the fetch is granted only after dwait pulses 0.
- Starvation (STARVE_LIMIT=4):
  - Stimulus: iREN held high; dREN re-asserted continuously.
  - Required: exactly 4 data completions, then a GRANT_I; starve_cnt returns to 0.
- Withdrawal:
  - Stimulus: dREN dropped mid-GRANT_D before ram_ack.
  - Required: ramREN=0 the same cycle; no dwait=0 pulse; state IDLE next cycle.
- Timeout (TIMEOUT=8):
  - Stimulus: ram_ack held 0 for 12 cycles, then 1.
  - Required: ram_err=1 from the cycle after to_cnt reaches 8; the access still completes when ack arrives; ram_err stays 1 until RST.
- Reset mid-grant:
  - Stimulus: RST pulsed while GRANT_D with ramWEN=1.
  - Required: ramWEN=0 and dwait=1 on the next cycle; no completion; starve_cnt=0.
